approx_mac_ctrl: RTL and testbench
==================================

Name: approx_mac_ctrl

Overview:
- Sequential front/back-end wrapped around the mul_9x9_signed_bw approximate multiplier.
- Accepts a job configuration: effective operand widths, approximation level and vector length.
- Sign-extends and registers each operand pair, and generates res_mask / appr_mask in hardware; software no longer does either.
- Accumulates the products of one job into a signed dot product and returns it over a valid/ready handshake.

Parameters:
- MAC_IN_WIDTH, 9: multiplier operand width.
- N_BIT_APPR, 8: appr_mask width passed to the multiplier.
- N_BIT_RES, 14: res_mask width.
- ACC_WIDTH, 32: accumulator width; must be >= 2*MAC_IN_WIDTH.
- CNT_WIDTH, 16: job-length counter width.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous, active-high reset.
- cfg_valid_i, in, 1: job configuration valid.
- cfg_ready_o, out, 1: controller idle; configuration can be accepted.
- cfg_width_a_i, in, 4: effective width of a (2..9).
- cfg_width_b_i, in, 4: effective width of b (2..9).
- cfg_appr_i, in, N_BIT_APPR: approximation level; 0 = exact.
- cfg_len_i, in, CNT_WIDTH: number of operand pairs in the job.
- in_valid_i, in, 1: operand pair valid.
- in_ready_o, out, 1: operand pair accepted this cycle when in_valid_i is also high.
- a_i, in, MAC_IN_WIDTH: raw operand a; only the low cfg_width_a bits are meaningful.
- b_i, in, MAC_IN_WIDTH: raw operand b; only the low cfg_width_b bits are meaningful.
- out_valid_o, out, 1: result valid.
- out_ready_i, in, 1: consumer accepts the result.
- acc_o, out, ACC_WIDTH: signed accumulated result.
- ovf_o, out, 1: sticky signed-overflow flag for the current job.
- busy_o, out, 1: high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state = IDLE. cfg_ready_o = 1; in_ready_o, out_valid_o and ovf_o = 0; acc_o = 0. All pipeline valids and counters are cleared. A reset during RUN, DRAIN or DONE discards the job and returns to IDLE on the next edge.
- States:
  - IDLE: cfg_ready_o = 1. On cfg_valid_i, latch cfg_*, clear acc and ovf, load counter with cfg_len_i. Go to RUN, or to DONE if cfg_len_i == 0 (acc_o = 0).
  - RUN: in_ready_o = 1 while remaining count > 0. Each accepted pair decrements the counter. Go to DRAIN in the cycle the last pair is accepted.
  - DRAIN: in_ready_o = 0. Wait until the S1 and S2 valids are both clear, then go to DONE.
  - DONE: out_valid_o = 1; acc_o and ovf_o are held stable. On out_ready_i go to IDLE.
- cfg_valid_i outside IDLE is ignored and not stalled. in_valid_i outside RUN is ignored.
- Width clamp: a latched width < 2 is treated as 2; > 9 is treated as 9.
- S1 (operand register): on accept, a_s1 = sign-extend(a_i[wa-1:0]) to MAC_IN_WIDTH; b_s1 is formed the same way. s1_valid = 1.
- Masks are combinational from the latched configuration, with weff = wa + wb:
  - res_mask[k] = 1 iff k < weff - 4, for k = 0..N_BIT_RES-1. If weff <= 4, res_mask = 0.
  - appr_mask = ~cfg_appr.
- The multiplier is combinational on S1 registers and masks.
- S2 (accumulate): when s1_valid, acc <= acc + sign-extend(res) to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH.
  - ovf is set if the two addends have the same sign and the sum sign differs; it stays set until the next job.
- Latency: the last accepted pair is reflected in acc_o 2 cycles later. out_valid_o rises no earlier than the cycle after that.
- Full throughput: one pair per cycle with no bubbles; in_ready_o does not depend on in_valid_i.

Decomposition:
- Package approx_mac_pkg:
  - state_e enum {IDLE, RUN, DRAIN, DONE}.
  - Constants MIN_W = 2, MAX_W = 9, RES_MASK_OFFSET = 4.
  - Function clamp_w.
- One sub-module, approx_mask_gen (combinational): inputs wa, wb, appr; outputs res_mask, appr_mask.
- mul_9x9_signed_bw is instantiated unchanged.

Test Plan:
- Exact dot product (wa = wb = 9, appr = 0, len = 3): pairs (3,4), (-5,6), (-256,-256) -> acc_o = 65518, ovf_o = 0. res_mask = 14'h3FFF, appr_mask = 8'hFF.
- Narrow width (wa = wb = 4, len = 1): a_i = 9'h00F, b_i = 9'h007 -> product -7, acc_o = -7, res_mask = 14'h000F.
- Zero length (cfg_len = 0) -> out_valid_o high in the cycle after cfg accept, acc_o = 0, no in_ready_o pulse.
- Overflow (bench ACC_WIDTH = 17, len = 2): (-256,-256) twice -> acc_o wraps to 0, ovf_o = 1. The next job clears ovf_o.
- Backpressure: hold out_ready_i low 5 cycles in DONE -> acc_o and out_valid_o stable, cfg_ready_o = 0. Raise out_ready_i -> IDLE the next cycle.
- Reset mid-RUN (len = 10, after 4 pairs): assert rst_i for 1 cycle -> IDLE, acc_o = 0, in_ready_o = 0. A new job with len = 1 and pair (2,3) yields acc_o = 6.

Source files
------------

// File: rtl/approx_mac_pkg.sv
// approx_mac_pkg: shared types and constants for the approximate MAC controller.
//   state_e   - controller FSM states
//   MIN_W / MAX_W      - legal range of effective operand widths
//   RES_MASK_OFFSET    - product bits below this index are always kept
//   clamp_w() - forces a configured width into [MIN_W, MAX_W]
package approx_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int MIN_W           = 2;
  localparam int MAX_W           = 9;
  localparam int RES_MASK_OFFSET = 4;

  function automatic logic [3:0] clamp_w(input logic [3:0] w);
    if (w < 4'(MIN_W)) return 4'(MIN_W);
    if (w > 4'(MAX_W)) return 4'(MAX_W);
    return w;
  endfunction

endpackage

// File: rtl/approx_mask_gen.sv
// approx_mask_gen: builds the multiplier masks from the latched job config.
//   wa, wb    - clamped effective operand widths
//   appr      - approximation level (0 = exact)
//   res_mask  - thermometer mask, bit k set iff k < wa + wb - RES_MASK_OFFSET
//   appr_mask - bitwise inverse of appr
module approx_mask_gen
  import approx_mac_pkg::*;
#(
  parameter int N_BIT_APPR = 8,
  parameter int N_BIT_RES  = 14
) (
  input  logic [3:0]            wa,
  input  logic [3:0]            wb,
  input  logic [N_BIT_APPR-1:0] appr,
  output logic [N_BIT_RES-1:0]  res_mask,
  output logic [N_BIT_APPR-1:0] appr_mask
);

  logic [4:0] weff;

  assign weff      = {1'b0, wa} + {1'b0, wb};
  assign appr_mask = ~appr;

  always_comb begin
    res_mask = '0;
    for (int k = 0; k < N_BIT_RES; k++) begin
      res_mask[k] = (k + RES_MASK_OFFSET) < int'(weff);
    end
  end

endmodule

// File: rtl/mul_9x9_signed_bw.sv
// mul_9x9_signed_bw: combinational 9x9 signed Baugh-Wooley multiplier with
// approximation controls.
//   a, b      - signed 9-bit operands
//   appr_mask - bit c = 0 drops every partial-product bit of column c (c < 8)
//   res_mask  - bit k = 0 replaces product bit k+4 with the bit below it, so
//               the result is sign-extended from the highest enabled bit
//   res       - 18-bit signed result
module mul_9x9_signed_bw (
  input  logic [8:0]  a,
  input  logic [8:0]  b,
  input  logic [13:0] res_mask,
  input  logic [7:0]  appr_mask,
  output logic [17:0] res
);

  logic [17:0] col_keep;
  logic [17:0] pp_sum;
  logic        pp;

  // Columns 8 and above are never approximated.
  assign col_keep = {10'h3FF, appr_mask};

  // NOTE: every variable written in always_comb gets a value before any
  // conditional update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    // Baugh-Wooley correction constants at columns 9 and 17.
    pp_sum = 18'h20200;
    pp     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 9; j++) begin
        pp = a[i] & b[j];
        // Terms pairing exactly one sign bit are complemented.
        if ((i == 8) != (j == 8)) pp = ~pp;
        if (!col_keep[i+j]) pp = 1'b0;
        pp_sum = pp_sum + (18'(pp) << (i + j));
      end
    end
  end

  always_comb begin
    res = pp_sum;
    // Ascending order lets a disabled bit copy an already-extended neighbour.
    for (int k = 0; k < 14; k++) begin
      if (!res_mask[k]) res[k+4] = res[k+3];
    end
  end

endmodule

// File: rtl/approx_mac_ctrl.sv
// approx_mac_ctrl: job controller wrapped around mul_9x9_signed_bw.
// Accepts a job config, streams operand pairs through a two-stage
// operand/accumulate pipeline and returns the signed dot product.
//   clk_i, rst_i          - clock, synchronous active-high reset
//   cfg_*                 - job configuration with valid/ready handshake
//   in_valid_i/in_ready_o - operand pair handshake (a_i, b_i raw operands)
//   out_valid_o/out_ready_i - result handshake (acc_o, ovf_o)
//   busy_o                - controller not idle
module approx_mac_ctrl
  import approx_mac_pkg::*;
#(
  parameter int MAC_IN_WIDTH = 9,
  parameter int N_BIT_APPR   = 8,
  parameter int N_BIT_RES    = 14,
  parameter int ACC_WIDTH    = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [3:0]              cfg_width_a_i,
  input  logic [3:0]              cfg_width_b_i,
  input  logic [N_BIT_APPR-1:0]   cfg_appr_i,
  input  logic [CNT_WIDTH-1:0]    cfg_len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [MAC_IN_WIDTH-1:0] a_i,
  input  logic [MAC_IN_WIDTH-1:0] b_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ACC_WIDTH-1:0]    acc_o,
  output logic                    ovf_o,
  output logic                    busy_o
);

  state_e                  state_q, state_d;
  logic [3:0]              wa_q, wb_q;
  logic [N_BIT_APPR-1:0]   appr_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [MAC_IN_WIDTH-1:0] a_ext, b_ext, a_s1, b_s1;
  logic                    s1_valid, s2_valid;
  logic [ACC_WIDTH-1:0]    acc_q, prod_ext, acc_sum;
  logic                    ovf_q, ovf_add;
  logic [N_BIT_RES-1:0]    res_mask;
  logic [N_BIT_APPR-1:0]   appr_mask;
  logic signed [17:0]      mul_res;
  logic                    cfg_accept, run_ready, in_accept;

  assign cfg_accept = (state_q == IDLE) && cfg_valid_i;
  // Readiness depends only on state and count, never on in_valid_i.
  assign run_ready  = (state_q == RUN) && (cnt_q != '0);
  assign in_accept  = run_ready && in_valid_i;
  assign in_ready_o = run_ready;

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cfg_valid_i) state_d = (cfg_len_i == '0) ? DONE : RUN;
      end
      RUN:   if (in_accept && cnt_q == CNT_WIDTH'(1)) state_d = DRAIN;
      DRAIN: if (!s1_valid && !s2_valid) state_d = DONE;
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign-extend from the configured width; bits above it are ignored.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    for (int k = 0; k < MAC_IN_WIDTH; k++) begin
      a_ext[k] = (k < int'(wa_q)) ? a_i[k] : a_i[wa_q-4'd1];
      b_ext[k] = (k < int'(wb_q)) ? b_i[k] : b_i[wb_q-4'd1];
    end
  end

  approx_mask_gen #(
    .N_BIT_APPR (N_BIT_APPR),
    .N_BIT_RES  (N_BIT_RES)
  ) u_mask_gen (
    .wa        (wa_q),
    .wb        (wb_q),
    .appr      (appr_q),
    .res_mask  (res_mask),
    .appr_mask (appr_mask)
  );

  mul_9x9_signed_bw u_mul (
    .a         (a_s1),
    .b         (b_s1),
    .res_mask  (res_mask),
    .appr_mask (appr_mask),
    .res       (mul_res)
  );

  // Sign-extends (or truncates for a narrow accumulator); the sum wraps.
  assign prod_ext = ACC_WIDTH'(mul_res);
  assign acc_sum  = acc_q + prod_ext;
  assign ovf_add  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wa_q     <= 4'(MAX_W);
      wb_q     <= 4'(MAX_W);
      appr_q   <= '0;
      cnt_q    <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_valid <= in_accept;
      s2_valid <= s1_valid;
      if (cfg_accept) begin
        wa_q   <= clamp_w(cfg_width_a_i);
        wb_q   <= clamp_w(cfg_width_b_i);
        appr_q <= cfg_appr_i;
        cnt_q  <= cfg_len_i;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (in_accept) cnt_q <= cnt_q - CNT_WIDTH'(1);
      if (s1_valid) begin
        acc_q <= acc_sum;
        ovf_q <= ovf_q | ovf_add;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are only consumed while
  // s1_valid is set, and s1_valid itself is reset.
  always_ff @(posedge clk_i) begin
    if (in_accept) begin
      a_s1 <= a_ext;
      b_s1 <= b_ext;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_approx_mac_ctrl.sv
// tb_approx_mac_ctrl: drives two controllers (32-bit and 17-bit accumulators)
// with the same directed jobs and compares both against a protocol-level
// model every cycle, plus literal expectations for the documented cases.
module tb_approx_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [3:0]  cfg_wa = 4'd9, cfg_wb = 4'd9;
  logic [7:0]  cfg_appr = 8'h00;
  logic [15:0] cfg_len = 16'd0;
  logic        in_valid = 1'b0;
  logic [8:0]  a = 9'd0, b = 9'd0;
  logic        out_ready = 1'b0;

  logic        cfg_ready32, in_ready32, out_valid32, ovf32, busy32;
  logic [31:0] acc32;
  logic        cfg_ready17, in_ready17, out_valid17, ovf17, busy17;
  logic [16:0] acc17;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_mac_ctrl #(.ACC_WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready32),
    .cfg_width_a_i(cfg_wa), .cfg_width_b_i(cfg_wb), .cfg_appr_i(cfg_appr),
    .cfg_len_i(cfg_len), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .a_i(a), .b_i(b), .out_valid_o(out_valid32), .out_ready_i(out_ready),
    .acc_o(acc32), .ovf_o(ovf32), .busy_o(busy32)
  );

  approx_mac_ctrl #(.ACC_WIDTH(17)) u_dut17 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready17),
    .cfg_width_a_i(cfg_wa), .cfg_width_b_i(cfg_wb), .cfg_appr_i(cfg_appr),
    .cfg_len_i(cfg_len), .in_valid_i(in_valid), .in_ready_o(in_ready17),
    .a_i(a), .b_i(b), .out_valid_o(out_valid17), .out_ready_i(out_ready),
    .acc_o(acc17), .ovf_o(ovf17), .busy_o(busy17)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mphase_e;
  typedef struct { longint p; int due; } pend_t;

  mphase_e    m_phase = M_IDLE;
  int         m_rem, m_wa, m_wb, m_done_at;
  logic [7:0] m_appr;
  longint     m_acc [2];
  bit         m_ovf [2];
  int         cyc = 0;
  pend_t      q_pend [$];
  localparam int WID [2] = '{32, 17};

  // Signed value of v reduced modulo 2^w.
  function automatic longint wrap(input longint v, input int w);
    longint m = longint'(1) << w;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int clamp(input logic [3:0] w);
    if (int'(w) < 2) return 2;
    if (int'(w) > 9) return 9;
    return int'(w);
  endfunction

  // Exact signed product minus the dropped low-column bit products, then
  // sign-extended from bit wa+wb-1.
  function automatic longint model_prod(input logic [8:0] ra, input logic [8:0] rb,
                                        input int wa, input int wb, input logic [7:0] appr);
    longint av = longint'(ra) & ((longint'(1) << wa) - 1);
    longint bv = longint'(rb) & ((longint'(1) << wb) - 1);
    longint drop = 0;
    longint ua, ub;
    if (av >= (longint'(1) << (wa - 1))) av -= longint'(1) << wa;
    if (bv >= (longint'(1) << (wb - 1))) bv -= longint'(1) << wb;
    ua = av & 'h1FF;
    ub = bv & 'h1FF;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i + j < 8)
          if (appr[i+j] && ((ua >> i) & 1) == 1 && ((ub >> j) & 1) == 1)
            drop += longint'(1) << (i + j);
    return wrap(av * bv - drop, wa + wb);
  endfunction

  task automatic acc_add(input int k, input longint p);
    longint y = wrap(p, WID[k]);
    longint s = m_acc[k] + y;
    longint lim = longint'(1) << (WID[k] - 1);
    if (s >= lim || s < -lim) m_ovf[k] = 1'b1;
    m_acc[k] = wrap(s, WID[k]);
  endtask

  task automatic model_step();
    cyc++;
    if (rst) begin
      m_phase = M_IDLE;
      m_rem   = 0;
      q_pend.delete();
      for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
      return;
    end
    while (q_pend.size() > 0 && q_pend[0].due == cyc) begin
      pend_t e = q_pend.pop_front();
      for (int k = 0; k < 2; k++) acc_add(k, e.p);
    end
    case (m_phase)
      M_IDLE: if (cfg_valid) begin
        m_wa   = clamp(cfg_wa);
        m_wb   = clamp(cfg_wb);
        m_appr = cfg_appr;
        for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
        if (cfg_len == 16'd0) m_phase = M_DONE;
        else begin m_rem = int'(cfg_len); m_phase = M_RUN; end
      end
      M_RUN: if (in_valid) begin
        // A pair accepted now is visible in acc_o after the next edge.
        q_pend.push_back('{model_prod(a, b, m_wa, m_wb, m_appr), cyc + 1});
        m_rem--;
        if (m_rem == 0) begin
          m_phase   = M_DRAIN;
          // Result is offered two cycles after the final accumulate lands.
          m_done_at = cyc + 3;
        end
      end
      M_DRAIN: if (cyc == m_done_at) m_phase = M_DONE;
      M_DONE:  if (out_ready) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("cfg_ready32", cfg_ready32, m_phase == M_IDLE);
      check("in_ready32",  in_ready32,  m_phase == M_RUN);
      check("out_valid32", out_valid32, m_phase == M_DONE);
      check("busy32",      busy32,      m_phase != M_IDLE);
      check("acc32",       $signed(acc32), m_acc[0]);
      check("ovf32",       ovf32,       m_ovf[0]);
      check("cfg_ready17", cfg_ready17, m_phase == M_IDLE);
      check("in_ready17",  in_ready17,  m_phase == M_RUN);
      check("out_valid17", out_valid17, m_phase == M_DONE);
      check("busy17",      busy17,      m_phase != M_IDLE);
      check("acc17",       $signed(acc17), m_acc[1]);
      check("ovf17",       ovf17,       m_ovf[1]);
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] q_a [$];
  logic [8:0] q_b [$];

  task automatic run_job(input int wa, input int wb, input logic [7:0] appr, input int len,
                         input int hold, input bit junk, input int abort_at, output int waits);
    int i = 0;
    int t = 0;
    waits = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_wa    = 4'(wa);
    cfg_wb    = 4'(wb);
    cfg_appr  = appr;
    cfg_len   = 16'(len);
    while (!cfg_ready32 && t < 20) begin @(negedge clk); t++; end
    check("cfg_accept", cfg_ready32, 1);
    // Stream pairs; a stray config offer is kept up to show it is ignored.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (i >= len || (abort_at >= 0 && i == abort_at)) break;
      cfg_valid = 1'b1;
      cfg_len   = 16'd7;
      in_valid  = 1'b1;
      a = q_a[i];
      b = q_b[i];
      if (in_ready32) i++;
    end
    cfg_valid = 1'b0;
    in_valid  = junk;
    a = 9'h155;
    b = 9'h0AA;
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check("pairs_sent", i, len);
    while (!out_valid32 && waits < 50) begin @(negedge clk); waits++; end
    check("out_valid_seen", out_valid32, 1);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    int w;
    @(negedge clk);
    @(negedge clk);
    check("rst_cfg_ready", cfg_ready32, 1);
    check("rst_in_ready",  in_ready32, 0);
    check("rst_out_valid", out_valid32, 0);
    check("rst_ovf",       ovf32, 0);
    check("rst_acc",       acc32, 0);
    check("rst_busy",      busy32, 0);
    rst = 1'b0;

    // Exact dot product, with 5 cycles of result backpressure.
    q_a = '{9'd3, 9'h1FB, 9'h100};
    q_b = '{9'd4, 9'd6,   9'h100};
    run_job(9, 9, 8'h00, 3, 5, 1'b0, -1, w);
    check("exact_acc",       $signed(acc32), 65518);
    check("exact_ovf",       ovf32, 0);
    check("exact_res_mask",  u_dut32.u_mask_gen.res_mask, 14'h3FFF);
    check("exact_appr_mask", u_dut32.u_mask_gen.appr_mask, 8'hFF);
    check("bp_back_idle",    cfg_ready32, 1);

    // Narrow operands.
    q_a = '{9'h00F};
    q_b = '{9'h007};
    run_job(4, 4, 8'h00, 1, 0, 1'b0, -1, w);
    check("narrow_acc",      $signed(acc32), -7);
    check("narrow_res_mask", u_dut32.u_mask_gen.res_mask, 14'h000F);

    // Zero length, with in_valid held high throughout.
    run_job(9, 9, 8'h00, 0, 0, 1'b1, -1, w);
    check("zero_len_wait", w, 0);
    check("zero_len_acc",  acc32, 0);

    // Overflow of the 17-bit accumulator.
    q_a = '{9'h100, 9'h100};
    q_b = '{9'h100, 9'h100};
    run_job(9, 9, 8'h00, 2, 0, 1'b0, -1, w);
    check("ovf17_acc",  acc17, 0);
    check("ovf17_flag", ovf17, 1);
    check("ovf32_acc",  $signed(acc32), 131072);
    check("ovf32_flag", ovf32, 0);

    // Out-of-range widths (15 -> 9, 0 -> 2) with approximation enabled.
    q_a = '{9'h0FF, 9'h1A5, 9'h07B};
    q_b = '{9'h001, 9'h003, 9'h002};
    run_job(15, 0, 8'h03, 3, 1, 1'b0, -1, w);
    check("next_job_ovf17",  ovf17, 0);
    check("clamp_res_mask",  u_dut32.u_mask_gen.res_mask, 14'h007F);
    check("clamp_appr_mask", u_dut32.u_mask_gen.appr_mask, 8'hFC);
    check("approx_first_pair", model_prod(9'h0FF, 9'h001, 9, 2, 8'h03), 252);

    // Reset during RUN after four pairs.
    q_a = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8, 9'd9, 9'd10};
    q_b = '{9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1, 9'd1};
    run_job(9, 9, 8'h00, 10, 0, 1'b0, 4, w);
    check("abort_cfg_ready", cfg_ready32, 1);
    check("abort_acc",       acc32, 0);
    check("abort_in_ready",  in_ready32, 0);

    q_a = '{9'd2};
    q_b = '{9'd3};
    run_job(9, 9, 8'h00, 1, 0, 1'b0, -1, w);
    check("after_abort_acc", $signed(acc32), 6);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
